pipe_ctrl: RTL and testbench

//  Central pipeline controller. Merges stall requests from ID (load-use) and EX, and produces the
//  per-stage hold vector for the PC, if_id, id_ex, ex_mem and mem_wb registers.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_mc_seq.sv | 87 ++++++++
 rtl/pipe_ctrl.sv | 78 +++++++
 tb/tb_pipe_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall vectors, sequencer states,
// the ERET exception code and reset polarity.
package pipe_ctrl_pkg;

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;

  localparam logic [31:0] EXC_ERET   = 32'h0000_000e;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic        RST_ENABLE = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mc_state_t;

endpackage

// File: rtl/pipe_mc_seq.sv
// Multi-cycle EX op sequencer: IDLE/RUN FSM with a remaining-cycle count and
// the phase index reported to EX.
module pipe_mc_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [MC_CNT_W-1:0] cycles,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [MC_CNT_W-1:0] phase_out,
  output logic                stall_req
);

  mc_state_t           state, state_n;
  logic [MC_CNT_W-1:0] cnt, cnt_n;
  logic [MC_CNT_W-1:0] phase, phase_n;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state <= IDLE;
      cnt   <= '0;
      phase <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      phase <= phase_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    phase_n   = phase;
    busy      = 1'b0;
    done      = 1'b0;
    stall_req = 1'b0;
    phase_out = phase;
    case (state)
      IDLE: begin
        if (req) begin
          if (cycles > MC_CNT_W'(1)) begin
            // cnt holds the RUN cycles still to go after the next one
            stall_req = 1'b1;
            state_n   = RUN;
            cnt_n     = cycles - MC_CNT_W'(2);
            phase_n   = MC_CNT_W'(1);
          end else begin
            done = 1'b1;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (!req) begin
          state_n = IDLE;
          cnt_n   = '0;
          phase_n = '0;
        end else if (cnt != '0) begin
          stall_req = 1'b1;
          cnt_n     = cnt - MC_CNT_W'(1);
          phase_n   = phase + MC_CNT_W'(1);
        end else begin
          done    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
          phase_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        phase_n = '0;
      end
    endcase
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      phase_n = '0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges ID/EX stall requests into the per-stage hold
// vector and owns the multi-cycle sequencer. Exception flush/redirect: PIPE_CTRL_EXC_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          MC_CNT_W   = 6,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id_i,
  input  logic                mc_req_i,
  input  logic [MC_CNT_W-1:0] mc_cycles_i,
  input  logic [31:0]         excepttype_i,
  input  logic [31:0]         cp0_epc_i,
  output logic [5:0]          stall_o,
  output logic                mc_busy_o,
  output logic [MC_CNT_W-1:0] mc_phase_o,
  output logic                mc_done_o,
  output logic                flush_o,
  output logic [31:0]         new_pc_o
);

  logic                exc;
  logic [31:0]         exc_pc;
  logic                seq_busy;
  logic                seq_done;
  logic [MC_CNT_W-1:0] seq_phase;
  logic                seq_stall;

`ifdef PIPE_CTRL_EXC_EN
  assign exc    = (excepttype_i != ZERO_WORD);
  assign exc_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
`else
  logic unused_exc_inputs;
  assign unused_exc_inputs = ^{excepttype_i, cp0_epc_i, EXC_VECTOR};
  assign exc    = 1'b0;
  assign exc_pc = ZERO_WORD;
`endif

  pipe_mc_seq #(
    .MC_CNT_W (MC_CNT_W)
  ) u_mc_seq (
    .clk       (clk),
    .rst       (rst),
    .req       (mc_req_i),
    .cycles    (mc_cycles_i),
    .abort     (exc),
    .busy      (seq_busy),
    .done      (seq_done),
    .phase_out (seq_phase),
    .stall_req (seq_stall)
  );

  // Priority merge: flush beats the EX sequencer, which beats the ID hazard.
  always_comb begin
    stall_o    = STALL_NONE;
    mc_busy_o  = 1'b0;
    mc_phase_o = '0;
    mc_done_o  = 1'b0;
    flush_o    = 1'b0;
    new_pc_o   = ZERO_WORD;
    if (rst != RST_ENABLE) begin
      mc_busy_o  = seq_busy;
      mc_phase_o = seq_phase;
      mc_done_o  = seq_done;
      if (exc) begin
        flush_o  = 1'b1;
        new_pc_o = exc_pc;
      end else if (seq_stall) begin
        stall_o = STALL_EX;
      end else if (stallreq_id_i) begin
        stall_o = STALL_ID;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model predicts each cycle's outputs,
// which are queued when inputs are driven and compared when the cycle is sampled.
module tb_pipe_ctrl;

  typedef struct packed {
    logic [5:0]  stall;
    logic        busy;
    logic [5:0]  phase;
    logic        done;
    logic        flush;
    logic [31:0] new_pc;
  } exp_t;

`ifdef PIPE_CTRL_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_id = 1'b0;
  logic        mc_req = 1'b0;
  logic [5:0]  mc_cycles = '0;
  logic [31:0] excepttype = '0;
  logic [31:0] cp0_epc = '0;
  logic [5:0]  stall;
  logic        mc_busy;
  logic [5:0]  mc_phase;
  logic        mc_done;
  logic        flush;
  logic [31:0] new_pc;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  // model state
  bit   m_busy  = 1'b0;
  int   m_phase = 0;
  int   m_n     = 0;

  pipe_ctrl #(
    .MC_CNT_W   (6),
    .EXC_VECTOR (32'h0000_0020)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id),
    .mc_req_i      (mc_req),
    .mc_cycles_i   (mc_cycles),
    .excepttype_i  (excepttype),
    .cp0_epc_i     (cp0_epc),
    .stall_o       (stall),
    .mc_busy_o     (mc_busy),
    .mc_phase_o    (mc_phase),
    .mc_done_o     (mc_done),
    .flush_o       (flush),
    .new_pc_o      (new_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic id, input logic req, input int n,
                      input logic [31:0] exc, input logic [31:0] epc, input string tag);
    exp_t e;
    bit   seq_stall;
    exp_t got;
    e = '0;
    seq_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = r; stallreq_id = id; mc_req = req; mc_cycles = 6'(n);
    excepttype = exc; cp0_epc = epc;
    if (r) begin
      m_busy = 1'b0;
    end else begin
      if (m_busy) begin
        e.busy  = 1'b1;
        e.phase = 6'(m_phase);
        if (!req) begin
          m_busy = 1'b0;
        end else if (m_phase == m_n - 1) begin
          e.done = 1'b1;
          m_busy = 1'b0;
        end else begin
          seq_stall = 1'b1;
          m_phase++;
        end
      end else if (req) begin
        if (n >= 2) begin
          seq_stall = 1'b1;
          m_busy  = 1'b1;
          m_phase = 1;
          m_n     = n;
        end else begin
          e.done = 1'b1;
        end
      end
      if (EXC_EN && exc != 0) begin
        e.flush  = 1'b1;
        e.new_pc = (exc == 32'h0000_000e) ? epc : 32'h0000_0020;
        m_busy   = 1'b0;
      end else if (seq_stall) begin
        e.stall = 6'b001111;
      end else if (id) begin
        e.stall = 6'b000111;
      end
    end
    sb_q.push_back(e);
    @(negedge clk);
    got = '{stall: stall, busy: mc_busy, phase: mc_phase, done: mc_done,
            flush: flush, new_pc: new_pc};
    if (sb_q.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".stall"},  32'(got.stall),  32'(e.stall));
      chk({tag, ".busy"},   32'(got.busy),   32'(e.busy));
      chk({tag, ".phase"},  32'(got.phase),  32'(e.phase));
      chk({tag, ".done"},   32'(got.done),   32'(e.done));
      chk({tag, ".flush"},  32'(got.flush),  32'(e.flush));
      chk({tag, ".new_pc"}, got.new_pc,      e.new_pc);
    end
  endtask

  initial begin
    // reset with every request asserted
    step(1, 1, 1, 5, 32'h1, 32'h400, "rst0");
    step(1, 1, 1, 5, 32'he, 32'h400, "rst1");
    step(0, 0, 0, 0, 0, 0, "idle");
    step(0, 0, 1, 1, 0, 0, "post_rst_single");
    step(0, 0, 0, 0, 0, 0, "idle");

    // ID load-use pulse
    step(0, 1, 0, 0, 0, 0, "id_pulse");
    step(0, 0, 0, 0, 0, 0, "id_after");

    // 5-cycle op; mc_cycles changes mid-run and must be ignored
    for (int i = 0; i < 5; i++) step(0, 0, 1, (i == 0) ? 5 : 2, 0, 0, "mc5");
    step(0, 0, 0, 0, 0, 0, "mc5_after");

    // single-cycle ops
    step(0, 0, 1, 1, 0, 0, "mc_n1");
    step(0, 0, 1, 0, 0, 0, "mc_n0");
    step(0, 0, 0, 0, 0, 0, "mc_n_after");

    // both stall sources, ID stall during RUN
    for (int i = 0; i < 3; i++) step(0, 1, 1, 3, 0, 0, "both");
    step(0, 1, 0, 0, 0, 0, "both_after");

    // cancel at phase 2 of a 10-cycle op
    step(0, 0, 1, 10, 0, 0, "cancel_p0");
    step(0, 0, 1, 10, 0, 0, "cancel_p1");
    step(0, 0, 0, 10, 0, 0, "cancel_p2");
    step(0, 0, 0, 0, 0, 0, "cancel_after");
    step(0, 0, 1, 1, 0, 0, "cancel_idle");
    step(0, 0, 0, 0, 0, 0, "idle");

    // exception at phase 3 of a 10-cycle op
    for (int i = 0; i < 3; i++) step(0, 0, 1, 10, 0, 0, "exc_run");
    step(0, 1, 1, 10, 32'h1, 32'h400, "exc_p3");
    step(0, 0, 0, 0, 0, 0, "exc_after");
    step(0, 0, 0, 0, 32'he, 32'h400, "eret");
    step(0, 0, 1, 2, 32'h4, 32'h0, "exc_idle_req");
    step(0, 0, 0, 0, 0, 0, "idle");

    // longest op: N = 2**MC_CNT_W-1
    for (int i = 0; i < 63; i++) step(0, 0, 1, 63, 0, 0, "mc63");
    step(0, 0, 0, 0, 0, 0, "mc63_after");

    // reset in the middle of RUN
    for (int i = 0; i < 2; i++) step(0, 0, 1, 8, 0, 0, "pre_rst");
    step(1, 0, 1, 8, 0, 0, "mid_rst");
    step(0, 0, 0, 0, 0, 0, "mid_rst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
